// File: rtl/pll_reset_sequencer.sv
// Staged reset release driven by PLL lock: core first, video later, with lock-loss tracking.
// Optional PLL_RSTSEQ_SYNC_EN adds a 2-flop synchroniser on locked_in.
module pll_reset_sequencer #(
    parameter int STABLE_CYCLES = 1024,
    parameter int STAGE_DELAY   = 16,
    parameter int CNT_W         = 8
) (
    input  logic             clock_in,
    input  logic             rst_in,
    input  logic             locked_in,
    input  logic             clear_in,
    output logic             rst_core_out,
    output logic             rst_video_out,
    output logic             ready_out,
    output logic             lock_lost_out,
    output logic [CNT_W-1:0] loss_cnt_out
);

    localparam int MAX_CYC = (STABLE_CYCLES > STAGE_DELAY) ? STABLE_CYCLES : STAGE_DELAY;
    localparam int TIMER_W = $clog2(MAX_CYC) + 1;
    localparam logic [TIMER_W-1:0] STABLE_LAST = TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DELAY_LAST  = TIMER_W'(STAGE_DELAY - 1);

    typedef enum logic [1:0] {WAIT_LOCK, STABLE, CORE_UP, RUN} state_t;

    state_t             state, state_nxt;
    logic [TIMER_W-1:0] timer, timer_nxt;
    logic               core_nxt, video_nxt, ready_nxt, flag_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               loss;
    logic               lk;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

`ifdef PLL_RSTSEQ_SYNC_EN
    logic sync_p0, sync_p1;

    always_ff @(posedge clock_in) begin
        if (rst_in) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= locked_in;
            sync_p1 <= sync_p0;
        end
    end

    assign lk = sync_p1;
`else
    assign lk = locked_in;
`endif

    always_ff @(posedge clock_in) begin
        if (rst_in) begin
            state         <= WAIT_LOCK;
            timer         <= '0;
            rst_core_out  <= 1'b1;
            rst_video_out <= 1'b1;
            ready_out     <= 1'b0;
            lock_lost_out <= 1'b0;
            loss_cnt_out  <= '0;
        end else begin
            state         <= state_nxt;
            timer         <= timer_nxt;
            rst_core_out  <= core_nxt;
            rst_video_out <= video_nxt;
            ready_out     <= ready_nxt;
            lock_lost_out <= flag_nxt;
            loss_cnt_out  <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        core_nxt  = rst_core_out;
        video_nxt = rst_video_out;
        ready_nxt = ready_out;
        flag_nxt  = lock_lost_out;
        cnt_nxt   = loss_cnt_out;
        loss      = 1'b0;

        // Clear is applied before any loss event in the same cycle.
        if (clear_in) begin
            flag_nxt = 1'b0;
            cnt_nxt  = '0;
        end

        case (state)
            WAIT_LOCK: begin
                timer_nxt = '0;
                core_nxt  = 1'b1;
                video_nxt = 1'b1;
                ready_nxt = 1'b0;
                if (lk) state_nxt = STABLE;
            end
            STABLE: begin
                if (!lk) begin
                    state_nxt = WAIT_LOCK;
                    timer_nxt = '0;
                end else if (timer == STABLE_LAST) begin
                    state_nxt = CORE_UP;
                    core_nxt  = 1'b0;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            CORE_UP: begin
                if (!lk) begin
                    loss = 1'b1;
                end else if (timer == DELAY_LAST) begin
                    state_nxt = RUN;
                    video_nxt = 1'b0;
                    ready_nxt = 1'b1;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            RUN: begin
                if (!lk) loss = 1'b1;
            end
            default: state_nxt = WAIT_LOCK;
        endcase

        if (loss) begin
            state_nxt = WAIT_LOCK;
            timer_nxt = '0;
            core_nxt  = 1'b1;
            video_nxt = 1'b1;
            ready_nxt = 1'b0;
            flag_nxt  = 1'b1;
            cnt_nxt   = sat_inc(cnt_nxt);
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: a lock-run-length model predicts outputs each cycle.
// Define PLL_RSTSEQ_SYNC_EN for both files to exercise the synchronised build.
module tb_pll_reset_sequencer;

    localparam int S  = 8;
    localparam int D  = 4;
    localparam int CW = 2;

    logic          clock_in = 1'b0;
    logic          rst_in, locked_in, clear_in;
    logic          rst_core_out, rst_video_out, ready_out, lock_lost_out;
    logic [CW-1:0] loss_cnt_out;

    always #5 clock_in = ~clock_in;

    pll_reset_sequencer #(
        .STABLE_CYCLES(S),
        .STAGE_DELAY  (D),
        .CNT_W        (CW)
    ) dut (
        .clock_in     (clock_in),
        .rst_in       (rst_in),
        .locked_in    (locked_in),
        .clear_in     (clear_in),
        .rst_core_out (rst_core_out),
        .rst_video_out(rst_video_out),
        .ready_out    (ready_out),
        .lock_lost_out(lock_lost_out),
        .loss_cnt_out (loss_cnt_out)
    );

    typedef struct packed {
        logic          core;
        logic          video;
        logic          ready;
        logic          flag;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_exp, mon_got;
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // Model: the only history that matters is how many consecutive edges lock has been seen high.
    int   run    = 0;
    logic m_flag = 1'b0;
    int   m_cnt  = 0;
    logic s1 = 1'b0, s2 = 1'b0;

    task automatic model_update(input logic r, input logic l, input logic c);
        logic lk;
        logic was_core;
        if (r) begin
            run = 0; m_flag = 1'b0; m_cnt = 0; s1 = 1'b0; s2 = 1'b0;
        end else begin
`ifdef PLL_RSTSEQ_SYNC_EN
            lk = s2; s2 = s1; s1 = l;
`else
            lk = l;
`endif
            was_core = (run >= S + 1);
            if (c) begin
                m_flag = 1'b0; m_cnt = 0;
            end
            if (!lk) begin
                if (was_core) begin
                    m_flag = 1'b1;
                    m_cnt  = (m_cnt + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt + 1;
                end
                run = 0;
            end else if (run < S + D + 1) begin
                run = run + 1;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.core  = !(run >= S + 1);
        e.video = !(run >= S + D + 1);
        e.ready = (run >= S + D + 1);
        e.flag  = m_flag;
        e.cnt   = CW'(m_cnt);
        return e;
    endfunction

    task automatic step(input logic r, input logic l, input logic c);
        @(negedge clock_in);
        rst_in = r; locked_in = l; clear_in = c;
        @(posedge clock_in);
        #1;
        model_update(r, l, c);
        sb_q.push_back(model_out());
    endtask

    task automatic hold(input logic l, input int n);
        for (int i = 0; i < n; i++) step(1'b0, l, 1'b0);
    endtask

    always @(negedge clock_in) begin
        cycle++;
        if (sb_q.size() > 0) begin
            mon_exp = sb_q.pop_front();
            mon_got = {rst_core_out, rst_video_out, ready_out, lock_lost_out, loss_cnt_out};
            checks++;
            if (mon_got !== mon_exp) begin
                errors++;
                $display("FAIL outputs cycle %0d got core=%b video=%b ready=%b flag=%b cnt=%0d expected core=%b video=%b ready=%b flag=%b cnt=%0d",
                         cycle, mon_got.core, mon_got.video, mon_got.ready, mon_got.flag, mon_got.cnt,
                         mon_exp.core, mon_exp.video, mon_exp.ready, mon_exp.flag, mon_exp.cnt);
            end
        end
    end

    initial begin
        logic lk_r;
        int   t;
        rst_in = 1'b1; locked_in = 1'b0; clear_in = 1'b0;

        // Reset, then a clean lock through both releases.
        repeat (3) step(1'b1, 1'b0, 1'b0);
        hold(1'b1, S + D + 4);

        // Glitch while still in the stability window: no count, restart timing.
        step(1'b1, 1'b0, 1'b0);
        hold(1'b1, 5);
        hold(1'b0, 1);
        hold(1'b1, S + D + 3);

        // Loss from RUN.
        hold(1'b0, 1);
        hold(1'b1, 2);

        // Repeated losses after core release saturate the counter, then clear with a loss.
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            hold(1'b1, S + 3);
            hold(1'b0, 1);
        end
        hold(1'b1, S + 3);
        step(1'b0, 1'b0, 1'b1);
        hold(1'b1, 3);

        // Reset asserted mid core-up stage, then full restart.
        step(1'b1, 1'b0, 1'b0);
        hold(1'b1, S + 2);
        step(1'b1, 1'b1, 1'b0);
        hold(1'b1, S + D + 4);

        // Lock toggling every cycle never releases anything.
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) step(1'b0, k[0], 1'b0);

        // Random lock runs with sporadic clears and resets.
        lk_r = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 19) == 0) lk_r = ~lk_r;
            step($urandom_range(0, 199) == 0, lk_r, $urandom_range(0, 15) == 0);
        end

        t = 0;
        while (sb_q.size() > 0 && t < 20) begin
            @(negedge clock_in);
            t++;
        end
        @(negedge clock_in);
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d expected=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
